// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear sequencing for a four-digit BCD stopwatch
// with a tick prescaler, saturating decade chain and multiplexed digit scan.
module stopwatch_ctrl #(
   parameter int TICK_DIV = 50000,
   parameter int SCAN_DIV = 1000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        btn_start,
   input  logic        btn_clear,
   output logic [15:0] count_bcd,
   output logic [3:0]  digit_sel,
   output logic [3:0]  bcd,
   output logic        running,
   output logic        full
);
   localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, FULL} state_t;
   state_t        state;
   logic          start_q, clear_q, start_p, clear_p, tick, carry;
   logic [PW-1:0] pre;
   logic [SW-1:0] scan;
   logic [1:0]    idx;
   logic [15:0]   cnt, nxt;
   assign start_p   = btn_start & ~start_q;
   assign clear_p   = btn_clear & ~clear_q;
   assign tick      = state == RUN && pre == PW'(TICK_DIV - 1);
   assign count_bcd = cnt;
   assign digit_sel = 4'b0001 << idx;
   assign bcd       = cnt[idx*4 +: 4];
   assign running   = state == RUN;
   assign full      = state == FULL;
   // decade carry ripples up only through digits sitting at 9
   always_comb begin
      carry = 1'b1;
      nxt = cnt;
      for (int i = 0; i < 4; i++) begin
         if (carry) nxt[i*4 +: 4] = cnt[i*4 +: 4] == 4'd9 ? 4'd0 : cnt[i*4 +: 4] + 4'd1;
         carry = carry & (cnt[i*4 +: 4] == 4'd9);
      end
   end
   // button history keeps sampling through reset so a held button never reads as a press
   always_ff @(posedge clock) begin
      start_q <= btn_start;
      clear_q <= btn_clear;
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         pre   <= '0;
         scan  <= '0;
         idx   <= '0;
      end else begin
         scan <= scan == SW'(SCAN_DIV - 1) ? '0 : scan + 1'b1;
         if (scan == SW'(SCAN_DIV - 1)) idx <= idx + 2'd1;
         pre <= state == RUN && !tick ? pre + 1'b1 : '0;
         case (state)
            IDLE:  if (start_p && !clear_p) state <= RUN;
            RUN: begin
               if (tick) cnt <= nxt;
               if (tick && nxt == 16'h9999) state <= FULL;
               else if (start_p) state <= PAUSE;
            end
            PAUSE: begin
               if (clear_p) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (start_p) state <= RUN;
            end
            FULL: begin
               if (clear_p) begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed and random stimulus checked every cycle against
// an integer-count reference model of the stopwatch.
module tb_stopwatch_ctrl;
   localparam int TD = 4;
   localparam int SD = 2;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_FULL = 3;
   logic        clock = 1'b0;
   logic        reset, btn_start, btn_clear;
   logic [15:0] count_bcd;
   logic [3:0]  digit_sel, bcd;
   logic        running, full;
   int n_pass = 0, n_chk = 0;
   int m_cnt = 0, m_mode = M_IDLE, m_phase = 0, m_scan = 0;
   bit ps_q = 1'b0, pc_q = 1'b0;

   stopwatch_ctrl #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
      .clock(clock), .reset(reset), .btn_start(btn_start), .btn_clear(btn_clear),
      .count_bcd(count_bcd), .digit_sel(digit_sel), .bcd(bcd),
      .running(running), .full(full)
   );

   always #5 clock = ~clock;

   function automatic logic [15:0] to_bcd(int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // one rising edge of the reference stopwatch
   task automatic model(bit s, bit c, bit r);
      bit sp, cp, tk;
      int old;
      sp = s & ~ps_q;
      cp = c & ~pc_q;
      ps_q = s;
      pc_q = c;
      if (r) begin
         m_mode = M_IDLE; m_cnt = 0; m_phase = 0; m_scan = 0;
         return;
      end
      m_scan++;
      old = m_mode;
      tk = 1'b0;
      if (old == M_RUN) begin
         m_phase++;
         if (m_phase == TD) begin tk = 1'b1; m_phase = 0; end
      end else m_phase = 0;
      if (old == M_RUN) begin
         if (tk) m_cnt++;
         if (tk && m_cnt == 9999) m_mode = M_FULL;
         else if (sp) m_mode = M_PAUSE;
      end else if (old == M_IDLE) begin
         if (sp && !cp) m_mode = M_RUN;
      end else if (cp) begin
         m_mode = M_IDLE; m_cnt = 0;
      end else if (old == M_PAUSE && sp) m_mode = M_RUN;
   endtask

   task automatic cyc(bit s, bit c, bit r = 1'b0);
      int idx, p;
      btn_start = s; btn_clear = c; reset = r;
      @(posedge clock);
      model(s, c, r);
      @(negedge clock);
      idx = (m_scan / SD) % 4;
      p = 1;
      repeat (idx) p *= 10;
      chk("count_bcd", count_bcd, to_bcd(m_cnt));
      chk("digit_sel", digit_sel, 32'(1) << idx);
      chk("bcd", bcd, (m_cnt / p) % 10);
      chk("running", running, m_mode == M_RUN);
      chk("full", full, m_mode == M_FULL);
   endtask

   task automatic run_until(int target, bit rnd_clear);
      int n = 0;
      while (m_cnt != target && n < 50000) begin
         cyc(1'b0, rnd_clear && ($urandom % 8 == 0));
         n++;
      end
      chk("reach_target", m_cnt, target);
   endtask

   initial begin
      btn_start = 1'b0; btn_clear = 1'b0; reset = 1'b1;
      repeat (3) cyc(1'b1, 1'b0, 1'b1);
      repeat (3) cyc(1'b1, 1'b0);
      chk("held_no_press", running, 1'b0);
      chk("held_count", count_bcd, 16'h0000);
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      chk("start_run", running, 1'b1);
      repeat (3) cyc(1'b1, 1'b0);
      chk("pre_first_tick", count_bcd, 16'h0000);
      cyc(1'b1, 1'b0);
      chk("first_tick", count_bcd, 16'h0001);
      repeat (36) cyc(1'b0, 1'b0);
      chk("tick_k40", count_bcd, 16'h0010);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
      chk("clear_in_run", running, 1'b1);
      run_until(99, 1'b1);
      run_until(100, 1'b1);
      chk("carry_0100", count_bcd, 16'h0100);
      run_until(999, 1'b1);
      run_until(1000, 1'b1);
      chk("carry_1000", count_bcd, 16'h1000);
      run_until(1234, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      repeat (12) cyc(1'b0, 1'b0);
      chk("pause_frozen", count_bcd, 16'h1234);
      chk("pause_not_running", running, 1'b0);
      cyc(1'b1, 1'b0);
      repeat (3) cyc(1'b0, 1'b0);
      chk("resume_hold", count_bcd, 16'h1234);
      cyc(1'b0, 1'b0);
      chk("resume_tick", count_bcd, 16'h1235);
      run_until(9998, 1'b1);
      run_until(9999, 1'b0);
      chk("full_flag", full, 1'b1);
      chk("full_not_running", running, 1'b0);
      cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b1, 1'b0);
      repeat (8) cyc(1'b0, 1'b0);
      chk("full_hold", count_bcd, 16'h9999);
      cyc(1'b0, 1'b1);
      chk("full_clear", count_bcd, 16'h0000);
      chk("full_clear_idle", full, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      repeat (10) cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b1);
      chk("both_in_pause_count", count_bcd, 16'h0000);
      chk("both_in_pause_idle", running, 1'b0);
      repeat (600) cyc($urandom % 6 == 0, $urandom % 10 == 0);
      cyc(1'b0, 1'b0); cyc(1'b0, 1'b1); cyc(1'b0, 1'b0);
      if (m_mode != M_RUN) cyc(1'b1, 1'b0);
      repeat (6) cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      chk("reset_mid_run", running, 1'b0);
      chk("reset_count", count_bcd, 16'h0000);
      chk("reset_sel", digit_sel, 4'b0001);
      repeat (5) cyc(1'b0, 1'b0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for a four-digit BCD stopwatch built from mod-10 digit counters and a multiplexed seven-segment display. It turns start/stop and clear buttons into a run/pause/clear state machine. It generates count ticks from a clock prescaler, cascades decade carries across four digits and saturates at 9999. It time-multiplexes one digit at a time onto a shared BCD output that feeds the downstream 7-segment decoder.

## Interface
- TICK_DIV, 50000: clock cycles per count tick (≥1).
- SCAN_DIV, 1000: clock cycles per display digit slot (≥1).
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock, one synchronous active-high reset, no other clock or reset.
- btn_start  in  1  start/stop button level, already debounced and in the clock domain.
- btn_clear  in  1  clear button level, already debounced and in the clock domain.
- count_bcd  out  16  digits {d3,d2,d1,d0}, 4 bits each, BCD, d0 least significant.
- digit_sel  out  4  one-hot active-high enable for the digit currently displayed.
- bcd  out  4  value of the selected digit.
- running  out  1  high in RUN.
- full  out  1  high in FULL.

## Operation
- Press detection: btn_*_q registers sample the buttons every cycle, including during reset. press = btn & ~btn_q. A button held through reset release produces no press.
- States: IDLE (count 0000), RUN, PAUSE, FULL.
- Transitions:
  - IDLE + start press → RUN.
  - RUN + start press → PAUSE.
  - PAUSE + start press → RUN.
  - PAUSE or FULL + clear press → IDLE, digits ← 0.
  - IDLE + clear press → stays IDLE.
  - Clear is ignored in RUN. Start is ignored in FULL.
- Simultaneous start+clear presses: clear wins in IDLE, PAUSE and FULL. In RUN, start is acted on (→PAUSE) and clear is ignored.
- Prescaler: 0..TICK_DIV-1. It increments only in RUN and is forced to 0 in any other state, so a partial interval is discarded on pause. tick = RUN & (prescaler == TICK_DIV-1); on tick the prescaler wraps to 0.
- Digit update on tick:
  - d0 increments.
  - di increments if all lower digits equal 9.
  - A digit at 9 that increments wraps to 0.
  - No digit ever holds a value above 9.
- Saturation: a tick that makes the count 9999 also moves the state to FULL on the same edge. The count then holds at 9999 until clear.
- A transition RUN→PAUSE on the same edge as a tick: the tick's increment is applied and the state becomes PAUSE.
- Scan: a free-running scan counter 0..SCAN_DIV-1 runs in all states. At wrap, digit index idx advances 0→1→2→3→0. digit_sel = 1<<idx; bcd = d[idx]. Both are combinational from registers.
- running and full are decoded from the state register.
- Reset values: state IDLE; digits 0000; both prescalers 0; idx 0; digit_sel 0001; bcd 0; running 0; full 0; count_bcd 0.

## Timing
- A button press sampled at edge k (input high at k, low at k-1) changes state at edge k. running/full reflect the new state after edge k.
- Entering RUN at edge k: the first increment occurs at edge k+TICK_DIV, then every TICK_DIV edges.
- Resuming from PAUSE restarts a full TICK_DIV interval.
- Clear in PAUSE/FULL at edge k: count_bcd = 0 after edge k.
- Each digit slot lasts exactly SCAN_DIV cycles; a full refresh is 4·SCAN_DIV cycles. bcd follows a digit change on the edge the digit changes (no added latency).
- Reset asserted mid-run: all registers take reset values at the next edge, regardless of state or ticks in flight.
- TICK_DIV=1: a tick occurs every RUN cycle. SCAN_DIV=1: idx advances every cycle.

## Test plan
All scenarios use TICK_DIV=4 and SCAN_DIV=2.
- Reset with btn_start held high, then release reset → state IDLE, count_bcd 0x0000, running 0, no press registered. A fresh low→high on btn_start then → running 1.
- Start press at edge k → count_bcd 0x0001 at edge k+4, 0x0010 at edge k+40, running stays 1.
- Carry chain: run until 0x0099, next tick → 0x0100. At 0x0999, next tick → 0x1000.
- Pause 2 cycles after a tick → count frozen. Clear while running → no effect. Resume at edge m → next increment at edge m+4, count preserved.
- Run to 0x9998, next tick → 0x9999, full 1, running 0. Further start presses → unchanged. Clear → 0x0000, IDLE.
- Scan with count 0x1234 in PAUSE:
  - digit_sel cycles 0001/0010/0100/1000, two cycles each, with bcd 4/3/2/1 respectively.
  - Simultaneous start+clear in PAUSE → IDLE, count 0x0000.
